// File: rtl/rgb_out_fifo.sv
// ---------------------------------------------------------------------------
// rgb_out_fifo
//
// Output stage that sits directly after the colour-transform core. The core
// cannot be stalled, so every pixel it strobes out is captured into a
// first-word-fall-through FIFO. The video sink then takes pixels over a
// valid/ready handshake. Each head pixel is tagged with start-of-frame and
// end-of-line flags that come from pixel/line counters. These counters step
// only when the sink actually takes a pixel.
//
// Parameters
//   DEPTH    FIFO entries (power of two, >= 4)
//   LINE_W   pixels per line (>= 2)
//   FRAME_H  lines per frame (>= 1)
//
// Ports
//   clk        system clock, rising edge
//   rst        asynchronous reset, active-high
//   in_valid   pixel strobe from the colour-transform core
//   in_data    RGB pixel {R[23:16], G[15:8], B[7:0]}
//   out_valid  head pixel available
//   out_ready  sink accepts the head pixel this cycle
//   out_data   head pixel
//   out_sof    head pixel is x=0, y=0 of the frame
//   out_eol    head pixel is the last pixel of its line
//   level      current FIFO occupancy, 0..DEPTH
//   ovf        sticky overflow flag, set when a pixel is dropped
//   ovf_clr    single-cycle pulse that clears ovf
// ---------------------------------------------------------------------------
module rgb_out_fifo #(
  parameter int DEPTH   = 16,
  parameter int LINE_W  = 640,
  parameter int FRAME_H = 480
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [23:0]              in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [23:0]              out_data,
  output logic                     out_sof,
  output logic                     out_eol,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     ovf,
  input  logic                     ovf_clr
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int XW = $clog2(LINE_W);
  // A one-line frame still needs a one-bit line counter so the logic stays legal.
  localparam int YW = (FRAME_H > 1) ? $clog2(FRAME_H) : 1;

  localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);
  localparam logic [LW-1:0] LVL_ONE  = LW'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [XW-1:0] X_LAST   = XW'(LINE_W - 1);
  localparam logic [YW-1:0] Y_LAST   = YW'(FRAME_H - 1);

  // Storage and state
  logic [23:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wrPtr;
  logic [AW-1:0] r_rdPtr;
  logic [LW-1:0] r_level;
  logic [23:0]   r_headData;
  logic          r_ovf;
  logic [XW-1:0] r_xCnt;
  logic [YW-1:0] r_yCnt;

  // Derived control
  logic          w_full;
  logic          w_empty;
  logic          w_pop;
  logic          w_push;
  logic          w_drop;
  logic [AW-1:0] w_rdPtrInc;
  logic [LW-1:0] w_levelNext;
  logic [23:0]   w_headNext;
  logic [XW-1:0] w_xNext;
  logic [YW-1:0] w_yNext;

  // Full and empty come from the occupancy count. This avoids the usual
  // pointer-equality ambiguity.
  // A pop frees the slot that a same-cycle push needs, so a full FIFO can still
  // accept a pixel when the sink is draining it.
  always_comb begin
    w_full     = (r_level == LVL_FULL);
    w_empty    = (r_level == '0);
    w_pop      = !w_empty && out_ready;
    w_push     = in_valid && (!w_full || w_pop);
    w_drop     = in_valid && w_full && !w_pop;
    w_rdPtrInc = r_rdPtr + PTR_ONE;
  end

  // The occupancy moves by one on a lone push or a lone pop. It is unchanged
  // when both happen or neither happens.
  always_comb begin
    w_levelNext = r_level;
    if (w_push && !w_pop)
      w_levelNext = r_level + LVL_ONE;
    else if (w_pop && !w_push)
      w_levelNext = r_level - LVL_ONE;
  end

  // The head register holds the pixel the sink sees next. This keeps out_data
  // a plain flop with no path from in_data. The head takes the incoming pixel
  // only when that pixel becomes the sole entry, so it shows up one edge after
  // the push and never in the same cycle. After a pop with more entries queued,
  // the head takes the slot behind the old head. That slot can never be the
  // one written at this edge.
  always_comb begin
    w_headNext = r_headData;
    if (w_push && (w_empty || (w_pop && r_level == LVL_ONE)))
      w_headNext = in_data;
    else if (w_pop && r_level > LVL_ONE)
      w_headNext = r_mem[w_rdPtrInc];
  end

  // The pixel position is for the pixel currently at the head. It steps past
  // the end of a line into the next line, and past the last line back to the
  // top of the frame.
  always_comb begin
    w_xNext = r_xCnt;
    w_yNext = r_yCnt;
    if (w_pop) begin
      if (r_xCnt == X_LAST) begin
        w_xNext = '0;
        w_yNext = (r_yCnt == Y_LAST) ? '0 : r_yCnt + YW'(1);
      end else begin
        w_xNext = r_xCnt + XW'(1);
      end
    end
  end

  // The pixel array has no reset. Stale entries are never visible because
  // occupancy gates everything the sink sees.
  always_ff @(posedge clk) begin
    if (w_push)
      r_mem[r_wrPtr] <= in_data;
  end

  // Pointers, occupancy and head register.
  // A reset in the middle of a stream throws away everything buffered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wrPtr    <= '0;
      r_rdPtr    <= '0;
      r_level    <= '0;
      r_headData <= '0;
    end else begin
      if (w_push)
        r_wrPtr <= r_wrPtr + PTR_ONE;
      if (w_pop)
        r_rdPtr <= w_rdPtrInc;
      r_level    <= w_levelNext;
      r_headData <= w_headNext;
    end
  end

  // Sticky overflow.
  // If a new drop lands in the same cycle as a clear, the drop wins, so no
  // loss goes unreported.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_ovf <= 1'b0;
    else if (w_drop)
      r_ovf <= 1'b1;
    else if (ovf_clr)
      r_ovf <= 1'b0;
  end

  // Frame position counters.
  // They step only when a pixel is actually handed to the sink. Dropped pixels
  // leave them unchanged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_xCnt <= '0;
      r_yCnt <= '0;
    end else begin
      r_xCnt <= w_xNext;
      r_yCnt <= w_yNext;
    end
  end

  // Every output is decoded from registers only, so in_valid and in_data never
  // reach the sink combinationally.
  // The tags stay on the same pixel for as long as the sink stalls.
  always_comb begin
    out_valid = !w_empty;
    out_data  = r_headData;
    out_sof   = !w_empty && (r_xCnt == '0) && (r_yCnt == '0);
    out_eol   = !w_empty && (r_xCnt == X_LAST);
    level     = r_level;
    ovf       = r_ovf;
  end

endmodule

// File: tb/tb_rgb_out_fifo.sv
// ---------------------------------------------------------------------------
// tb_rgb_out_fifo
//
// Self-checking bench for rgb_out_fifo, built with DEPTH=16, LINE_W=4 and
// FRAME_H=2 so that frame wrap-around happens quickly. A queue-based reference
// model tracks the buffered pixels, the sticky overflow flag and the count of
// pixels handed to the sink. The expected frame tags are worked out
// arithmetically from that pop count.
// ---------------------------------------------------------------------------
module tb_rgb_out_fifo;

  localparam int DEPTH   = 16;
  localparam int LINE_W  = 4;
  localparam int FRAME_H = 2;
  localparam int LVW     = $clog2(DEPTH) + 1;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            in_valid = 1'b0;
  logic [23:0]     in_data = '0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [23:0]     out_data;
  logic            out_sof;
  logic            out_eol;
  logic [LVW-1:0]  level;
  logic            ovf;
  logic            ovf_clr = 1'b0;

  int compares = 0;
  int errors   = 0;

  // Reference model state
  logic [23:0] mq[$];
  int          mPops = 0;
  logic        mOvf  = 1'b0;

  rgb_out_fifo #(
    .DEPTH  (DEPTH),
    .LINE_W (LINE_W),
    .FRAME_H(FRAME_H)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_sof  (out_sof),
    .out_eol  (out_eol),
    .level    (level),
    .ovf      (ovf),
    .ovf_clr  (ovf_clr)
  );

  always #5 clk = ~clk;

  // Model: empty FIFO, counters back at the top of the frame.
  task automatic modelReset();
    mq.delete();
    mPops = 0;
    mOvf  = 1'b0;
  endtask

  function automatic logic expSof();
    return (mq.size() != 0) && ((mPops % (LINE_W * FRAME_H)) == 0);
  endfunction

  function automatic logic expEol();
    return (mq.size() != 0) && ((mPops % LINE_W) == LINE_W - 1);
  endfunction

  // Drive one clock of inputs, update the model with the same rules, then
  // step to 1ns after the rising edge, where outputs are sampled.
  task automatic applyStimulus(input logic iv, input logic [23:0] id,
                               input logic rdy, input logic clr);
    logic full, pop, push, drop;
    in_valid  = iv;
    in_data   = id;
    out_ready = rdy;
    ovf_clr   = clr;
    full = (mq.size() == DEPTH);
    pop  = (mq.size() != 0) && rdy;
    push = iv && (!full || pop);
    drop = iv && full && !pop;
    if (pop) begin
      void'(mq.pop_front());
      mPops++;
    end
    if (push) mq.push_back(id);
    if (drop) mOvf = 1'b1;
    else if (clr) mOvf = 1'b0;
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    ovf_clr   = 1'b0;
  endtask

  task automatic doReset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    modelReset();
  endtask

  // Reset with in_valid high must hold everything empty. The first pixel after
  // release appears one edge later, tagged as start of frame.
  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b1;
    in_data = 24'h123456;
    repeat (2) @(posedge clk);
    #1;
    modelReset();
    compares++;
    if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b expected 0", out_valid); end
    compares++;
    if (level !== '0) begin errors++; $display("[TB] FAIL reset_level: got %0d expected 0", level); end
    compares++;
    if (ovf !== 1'b0) begin errors++; $display("[TB] FAIL reset_ovf: got %b expected 0", ovf); end
    compares++;
    if (out_data !== 24'h0) begin errors++; $display("[TB] FAIL reset_data: got %h expected 000000", out_data); end
    in_valid = 1'b0;
    rst = 1'b0;
    applyStimulus(1'b0, 24'h0, 1'b0, 1'b0);
    applyStimulus(1'b1, 24'hFF0000, 1'b0, 1'b0);
    compares++;
    if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL first_valid: got %b expected 1", out_valid); end
    compares++;
    if (out_data !== 24'hFF0000) begin errors++; $display("[TB] FAIL first_data: got %h expected ff0000", out_data); end
    compares++;
    if (out_sof !== 1'b1) begin errors++; $display("[TB] FAIL first_sof: got %b expected 1", out_sof); end
    applyStimulus(1'b0, 24'h0, 1'b1, 1'b0);
    compares++;
    if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL first_drain: got %b expected 0", out_valid); end
  endtask

  // Streaming with the sink always ready: each new pixel becomes the head
  // right after its push. Occupancy stays at one and nothing is lost.
  task automatic test_ordering();
    for (int k = 1; k <= 16; k++) begin
      applyStimulus(1'b1, 24'(k), 1'b1, 1'b0);
      compares++;
      if (out_valid !== 1'b1 || out_data !== 24'(k)) begin
        errors++;
        $display("[TB] FAIL order_%0d: got v=%b d=%h expected v=1 d=%h", k, out_valid, out_data, 24'(k));
      end
      compares++;
      if (level !== LVW'(1) || ovf !== 1'b0) begin
        errors++;
        $display("[TB] FAIL order_lvl_%0d: got level=%0d ovf=%b expected level=1 ovf=0", k, level, ovf);
      end
    end
    applyStimulus(1'b0, 24'h0, 1'b1, 1'b0);
    compares++;
    if (level !== '0) begin errors++; $display("[TB] FAIL order_drain: got %0d expected 0", level); end
  endtask

  // Seventeen pixels with the sink stalled: the last one is dropped and ovf is
  // set. Draining returns exactly the first sixteen, and ovf_clr clears the flag.
  task automatic test_overflow();
    for (int k = 1; k <= 17; k++) applyStimulus(1'b1, 24'h100 + 24'(k), 1'b0, 1'b0);
    compares++;
    if (level !== LVW'(16)) begin errors++; $display("[TB] FAIL ovf_level: got %0d expected 16", level); end
    compares++;
    if (ovf !== 1'b1) begin errors++; $display("[TB] FAIL ovf_set: got %b expected 1", ovf); end
    for (int k = 1; k <= 16; k++) begin
      compares++;
      if (out_valid !== 1'b1 || out_data !== 24'h100 + 24'(k)) begin
        errors++;
        $display("[TB] FAIL ovf_drain_%0d: got v=%b d=%h expected v=1 d=%h", k, out_valid, out_data, 24'h100 + 24'(k));
      end
      applyStimulus(1'b0, 24'h0, 1'b1, 1'b0);
    end
    compares++;
    if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL ovf_lost: got %b expected 0", out_valid); end
    applyStimulus(1'b0, 24'h0, 1'b0, 1'b1);
    compares++;
    if (ovf !== 1'b0) begin errors++; $display("[TB] FAIL ovf_clr: got %b expected 0", ovf); end
  endtask

  // Push and pop in the same cycle while full: the new pixel is accepted and
  // occupancy stays at DEPTH. Then check that a drop beats a clear in the same cycle.
  task automatic test_full_pop();
    for (int k = 1; k <= 16; k++) applyStimulus(1'b1, 24'h200 + 24'(k), 1'b0, 1'b0);
    applyStimulus(1'b1, 24'hABCDEF, 1'b1, 1'b0);
    compares++;
    if (level !== LVW'(16) || ovf !== 1'b0) begin
      errors++;
      $display("[TB] FAIL fullpop: got level=%0d ovf=%b expected level=16 ovf=0", level, ovf);
    end
    for (int k = 2; k <= 17; k++) begin
      logic [23:0] want;
      want = (k == 17) ? 24'hABCDEF : 24'h200 + 24'(k);
      compares++;
      if (out_valid !== 1'b1 || out_data !== want) begin
        errors++;
        $display("[TB] FAIL fullpop_drain_%0d: got v=%b d=%h expected v=1 d=%h", k, out_valid, out_data, want);
      end
      applyStimulus(1'b0, 24'h0, 1'b1, 1'b0);
    end
    for (int k = 0; k < 16; k++) applyStimulus(1'b1, 24'($urandom), 1'b0, 1'b0);
    applyStimulus(1'b1, 24'h555555, 1'b0, 1'b1);
    compares++;
    if (ovf !== 1'b1 || level !== LVW'(16)) begin
      errors++;
      $display("[TB] FAIL set_wins: got ovf=%b level=%0d expected ovf=1 level=16", ovf, level);
    end
    applyStimulus(1'b0, 24'h0, 1'b0, 1'b1);
    for (int k = 0; k < 16; k++) applyStimulus(1'b0, 24'h0, 1'b1, 1'b0);
  endtask

  // A 4x2 frame: nine pops span one whole frame plus the first pixel of the
  // next. The sink stalls at random, and the tags must stay on the same pixel
  // through every stall.
  task automatic test_framing();
    int pops, cycles, p;
    logic rdy;
    doReset();
    for (int k = 1; k <= 9; k++) applyStimulus(1'b1, 24'h500 + 24'(k), 1'b0, 1'b0);
    pops = 0;
    cycles = 0;
    while (pops < 9 && cycles < 200) begin
      p = pops + 1;
      rdy = ($urandom_range(0, 2) != 0);
      compares++;
      if (out_valid !== 1'b1 || out_data !== 24'h500 + 24'(p)) begin
        errors++;
        $display("[TB] FAIL frame_data_%0d: got v=%b d=%h expected v=1 d=%h", p, out_valid, out_data, 24'h500 + 24'(p));
      end
      compares++;
      if (out_sof !== (p == 1 || p == 9) || out_eol !== (p == 4 || p == 8)) begin
        errors++;
        $display("[TB] FAIL frame_tags_%0d: got sof=%b eol=%b expected sof=%b eol=%b",
                 p, out_sof, out_eol, (p == 1 || p == 9), (p == 4 || p == 8));
      end
      applyStimulus(1'b0, 24'h0, rdy, 1'b0);
      if (rdy) pops++;
      cycles++;
    end
    compares++;
    if (pops != 9) begin errors++; $display("[TB] FAIL frame_budget: got %0d pops expected 9", pops); end
  endtask

  // A reset after five pops empties the FIFO immediately. The next pixel out
  // is the start of a new frame.
  task automatic test_midframe_reset();
    doReset();
    for (int k = 1; k <= 8; k++) applyStimulus(1'b1, 24'h600 + 24'(k), 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) applyStimulus(1'b0, 24'h0, 1'b1, 1'b0);
    rst = 1'b1;
    #2;
    compares++;
    if (out_valid !== 1'b0 || level !== '0) begin
      errors++;
      $display("[TB] FAIL midrst_empty: got v=%b level=%0d expected v=0 level=0", out_valid, level);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    modelReset();
    applyStimulus(1'b1, 24'h777777, 1'b0, 1'b0);
    compares++;
    if (out_valid !== 1'b1 || out_sof !== 1'b1 || out_data !== 24'h777777) begin
      errors++;
      $display("[TB] FAIL midrst_sof: got v=%b sof=%b d=%h expected v=1 sof=1 d=777777", out_valid, out_sof, out_data);
    end
    applyStimulus(1'b0, 24'h0, 1'b1, 1'b0);
  endtask

  // Random traffic checked every cycle against the queue model. The first half
  // leans towards a stalled sink and the second half towards a draining one.
  task automatic test_random();
    logic iv, rdy, clr;
    for (int c = 0; c < 600; c++) begin
      compares++;
      if (out_valid !== (mq.size() != 0) || level !== LVW'(mq.size()) || ovf !== mOvf) begin
        errors++;
        $display("[TB] FAIL rand_state_%0d: got v=%b level=%0d ovf=%b expected v=%b level=%0d ovf=%b",
                 c, out_valid, level, ovf, (mq.size() != 0), mq.size(), mOvf);
      end
      if (mq.size() != 0) begin
        compares++;
        if (out_data !== mq[0] || out_sof !== expSof() || out_eol !== expEol()) begin
          errors++;
          $display("[TB] FAIL rand_head_%0d: got d=%h sof=%b eol=%b expected d=%h sof=%b eol=%b",
                   c, out_data, out_sof, out_eol, mq[0], expSof(), expEol());
        end
      end
      iv  = ($urandom_range(0, 99) < 60);
      rdy = ($urandom_range(0, 99) < ((c < 300) ? 35 : 75));
      clr = ($urandom_range(0, 99) < 4);
      applyStimulus(iv, 24'($urandom), rdy, clr);
    end
  endtask

  initial begin
    test_reset();
    test_ordering();
    test_overflow();
    test_full_pop();
    test_framing();
    test_midframe_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, errors);
    $finish;
  end

endmodule
